reg_forward_scoreboard: RTL and testbench



---
 rtl/reg_forward_scoreboard.sv | 113 +++++++++++
 tb/tb_reg_forward_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_forward_scoreboard.sv
// Decode-stage operand read unit: forwards from in-flight stages and the
// long-latency completion port, tracks multi-cycle producers, and raises stall.
module reg_forward_scoreboard #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int RD_PORTS   = 2,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS*DATA_W-1:0]   rf_data,
  input  logic [FWD_STAGES-1:0]        fwd_we,
  input  logic [FWD_STAGES*ADDR_W-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic [FWD_STAGES-1:0]        fwd_ready,
  input  logic                         issue_valid,
  input  logic                         issue_long,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         cmpl_valid,
  input  logic [ADDR_W-1:0]            cmpl_addr,
  input  logic [DATA_W-1:0]            cmpl_data,
  input  logic                         flush,
  input  logic                         stat_clr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic                         stall,
  output logic [(1<<ADDR_W)-1:0]       pending,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [ADDR_W-1:0] w_addr     [RD_PORTS];
  logic [DATA_W-1:0] w_data     [RD_PORTS];
  logic              w_fwd_hit  [RD_PORTS];
  logic              w_fwd_rdy  [RD_PORTS];
  logic              w_cmpl_hit [RD_PORTS];
  logic              w_hazard   [RD_PORTS];
  logic              w_stall;

  // Operand resolution: the stage loop runs oldest-to-youngest so the
  // youngest matching stage overwrites older ones and wins.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before any
    // conditional update, so no path leaves it holding a value (no latch).
    rd_data = '0;
    w_stall = 1'b0;
    for (int i = 0; i < RD_PORTS; i++) begin
      w_addr[i]     = rd_addr[i*ADDR_W +: ADDR_W];
      w_data[i]     = rf_data[i*DATA_W +: DATA_W];
      w_fwd_hit[i]  = 1'b0;
      w_fwd_rdy[i]  = 1'b1;
      w_cmpl_hit[i] = cmpl_valid && (cmpl_addr == w_addr[i]);
      if (w_cmpl_hit[i]) w_data[i] = cmpl_data;
      for (int j = FWD_STAGES - 1; j >= 0; j--) begin
        if (fwd_we[j] && (fwd_addr[j*ADDR_W +: ADDR_W] == w_addr[i])) begin
          w_fwd_hit[i] = 1'b1;
          w_fwd_rdy[i] = fwd_ready[j];
          w_data[i]    = fwd_data[j*DATA_W +: DATA_W];
        end
      end
      if (w_addr[i] == '0) w_data[i] = '0;

      w_hazard[i] = rd_en[i] && (w_addr[i] != '0) &&
                    ((w_fwd_hit[i] && !w_fwd_rdy[i]) ||
                     (r_pending[w_addr[i]] && !w_cmpl_hit[i]));
      w_stall = w_stall | w_hazard[i];
      rd_data[i*DATA_W +: DATA_W] = w_data[i];
    end
  end

  // Issue set beats completion clear so a back-to-back reissue stays tracked.
  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_valid && issue_long && !w_stall && (issue_addr == ADDR_W'(r)))
          w_pending_nxt[r] = 1'b1;
        else if (cmpl_valid && (cmpl_addr == ADDR_W'(r)))
          w_pending_nxt[r] = 1'b0;
      end
    end
    w_pending_nxt[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (stat_clr)
        r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall     = w_stall;
  assign pending   = r_pending;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_reg_forward_scoreboard.sv
// Directed self-checking bench for reg_forward_scoreboard (CNT_W=4 build so
// counter saturation is reachable quickly).
module tb_reg_forward_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int RDP    = 2;
  localparam int FWS    = 2;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    rst_n;
  logic [RDP-1:0]          rd_en;
  logic [RDP*ADDR_W-1:0]   rd_addr;
  logic [RDP*DATA_W-1:0]   rf_data;
  logic [FWS-1:0]          fwd_we;
  logic [FWS*ADDR_W-1:0]   fwd_addr;
  logic [FWS*DATA_W-1:0]   fwd_data;
  logic [FWS-1:0]          fwd_ready;
  logic                    issue_valid;
  logic                    issue_long;
  logic [ADDR_W-1:0]       issue_addr;
  logic                    cmpl_valid;
  logic [ADDR_W-1:0]       cmpl_addr;
  logic [DATA_W-1:0]       cmpl_data;
  logic                    flush;
  logic                    stat_clr;
  logic [RDP*DATA_W-1:0]   rd_data;
  logic                    stall;
  logic [(1<<ADDR_W)-1:0]  pending;
  logic [CNT_W-1:0]        stall_cnt;

  int n_cmp;
  int n_err;

  reg_forward_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RDP),
    .FWD_STAGES(FWS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rf_data(rf_data), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_ready(fwd_ready), .issue_valid(issue_valid),
    .issue_long(issue_long), .issue_addr(issue_addr), .cmpl_valid(cmpl_valid),
    .cmpl_addr(cmpl_addr), .cmpl_data(cmpl_data), .flush(flush),
    .stat_clr(stat_clr), .rd_data(rd_data), .stall(stall),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; rf_data = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_ready = '1;
    issue_valid = 1'b0; issue_long = 1'b0; issue_addr = '0;
    cmpl_valid = 1'b0; cmpl_addr = '0; cmpl_data = '0;
    flush = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic issue_long_to(input logic [ADDR_W-1:0] a);
    issue_valid = 1'b1; issue_long = 1'b1; issue_addr = a;
  endtask

  // Each vector: apply at the falling edge, check combinational results 1ns
  // later; the following rising edge then samples the same inputs.
  task automatic vec();
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #1;
    check("reset_pending", pending, 32'h0);
    check("reset_cnt", 32'(stall_cnt), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- forwarding priority ----
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd5; rf_data[31:0] = 32'h1111;
    fwd_we = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
    #1;
    check("prio_youngest", rd_data[31:0], 32'hAAAA);
    check("prio_stall", 32'(stall), 32'h0);
    fwd_we = 2'b10;
    #1;
    check("prio_older", rd_data[31:0], 32'hBBBB);
    fwd_we = 2'b00; cmpl_valid = 1'b1; cmpl_addr = 5'd5; cmpl_data = 32'hCCCC;
    #1;
    check("prio_cmpl", rd_data[31:0], 32'hCCCC);
    cmpl_valid = 1'b0;
    #1;
    check("prio_rf", rd_data[31:0], 32'h1111);

    // ---- zero register ----
    vec();
    rd_en = 2'b11; rd_addr = '0; rf_data = {32'h5555, 32'h6666};
    fwd_we = 2'b11; fwd_addr = '0; fwd_data = {32'h7777, 32'h8888};
    fwd_ready = 2'b01;
    cmpl_valid = 1'b1; cmpl_addr = '0; cmpl_data = 32'h9999;
    issue_long_to(5'd0);
    #1;
    check("zero_rd0", rd_data[31:0], 32'h0);
    check("zero_rd1", rd_data[63:32], 32'h0);
    check("zero_stall", 32'(stall), 32'h0);
    vec();
    #1;
    check("zero_pending", pending, 32'h0);

    // ---- load-use ----
    vec();
    fwd_we = 2'b01; fwd_addr[4:0] = 5'd8; fwd_data[31:0] = 32'h88; fwd_ready = 2'b10;
    rd_en = 2'b10; rd_addr[9:5] = 5'd8;
    #1;
    check("lu_stall", 32'(stall), 32'h1);                 // edge -> cnt 1
    vec();
    fwd_we = 2'b01; fwd_addr[4:0] = 5'd8; fwd_data[31:0] = 32'h88; fwd_ready = 2'b10;
    rd_en = 2'b00; rd_addr[9:5] = 5'd8;
    #1;
    check("lu_no_en", 32'(stall), 32'h0);
    vec();
    fwd_we = 2'b01; fwd_addr[4:0] = 5'd8; fwd_data[31:0] = 32'h88; fwd_ready = 2'b10;
    rd_en = 2'b10; rd_addr[9:5] = 5'd8;
    #1;
    check("lu_stall_again", 32'(stall), 32'h1);           // edge -> cnt 2
    vec();
    fwd_we = 2'b01; fwd_addr[4:0] = 5'd8; fwd_data[31:0] = 32'h88; fwd_ready = 2'b11;
    rd_en = 2'b10; rd_addr[9:5] = 5'd8;
    #1;
    check("lu_ready_stall", 32'(stall), 32'h0);
    check("lu_ready_data", rd_data[63:32], 32'h88);
    check("lu_cnt", 32'(stall_cnt), 32'd2);

    // ---- scoreboard ----
    vec();
    issue_long_to(5'd9);
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd9; rf_data[31:0] = 32'hDEAD;
    #1;
    check("sb_pending9", 32'(pending[9]), 32'h1);
    check("sb_stall", 32'(stall), 32'h1);                 // edge -> cnt 3
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd9; rf_data[31:0] = 32'hDEAD;
    cmpl_valid = 1'b1; cmpl_addr = 5'd9; cmpl_data = 32'h1234;
    #1;
    check("sb_cmpl_stall", 32'(stall), 32'h0);
    check("sb_cmpl_data", rd_data[31:0], 32'h1234);
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd9; rf_data[31:0] = 32'hDEAD;
    #1;
    check("sb_cleared", 32'(pending[9]), 32'h0);
    check("sb_rf_data", rd_data[31:0], 32'hDEAD);
    check("sb_cnt", 32'(stall_cnt), 32'd3);
    vec();
    issue_long_to(5'd9);
    vec();
    issue_long_to(5'd9);
    cmpl_valid = 1'b1; cmpl_addr = 5'd9; cmpl_data = 32'h1;
    #1;
    check("sb_set_again", 32'(pending[9]), 32'h1);
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd9;
    issue_long_to(5'd10);                                 // stalled -> ignored; cnt 4
    #1;
    check("sb_set_wins", 32'(pending[9]), 32'h1);
    check("sb_issue_stalled", 32'(stall), 32'h1);
    vec();
    #1;
    check("sb_r10_ignored", 32'(pending[10]), 32'h0);
    check("sb_cnt2", 32'(stall_cnt), 32'd4);

    // ---- flush ----
    vec();
    issue_long_to(5'd3);
    vec();
    issue_long_to(5'd7);
    vec();
    flush = 1'b1;
    #1;
    check("fl_before", pending, 32'h0000_0288);
    vec();
    #1;
    check("fl_after", pending, 32'h0);

    // ---- asynchronous reset mid-stall ----
    vec();
    issue_long_to(5'd3);
    vec();
    rd_en = 2'b01; rd_addr[4:0] = 5'd3;
    #1;
    check("rst_pre_pending", pending, 32'h0000_0008);
    check("rst_pre_stall", 32'(stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_pending", pending, 32'h0);
    check("rst_cnt", 32'(stall_cnt), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- saturating counter ----
    vec();
    fwd_we = 2'b01; fwd_addr[4:0] = 5'd8; fwd_ready = 2'b10;
    rd_en = 2'b10; rd_addr[9:5] = 5'd8;
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    @(negedge clk);
    #1;
    check("cnt_saturate", 32'(stall_cnt), 32'd15);
    check("cnt_stall_held", 32'(stall), 32'h1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("cnt_clear", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #1;
    check("cnt_resume", 32'(stall_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
